// File: rtl/axi_crossbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_crossbar_pkg
// Description : Shared types and helpers for the crossbar arbitration logic.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_crossbar_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Grant-index width for a given requester count; never narrower than 1 bit.
  function automatic int calc_id_w(input int req_nb);
    return (req_nb <= 1) ? 1 : $clog2(req_nb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_crossbar_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : axi_crossbar_rr_picker
// Description : Combinational round-robin winner search. Rotates the request
//               vector so the slot after last_id lands at bit 0, then picks
//               the lowest set bit and maps it back to an absolute index.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_crossbar_rr_picker
  import axi_crossbar_pkg::*;
#(
  parameter int REQ_NB = 4,
  parameter int ID_W   = calc_id_w(REQ_NB)
) (
  input  logic [REQ_NB-1:0] req_i,
  input  logic [ID_W-1:0]   last_id_i,
  output logic [ID_W-1:0]   winner_o,
  output logic              found_o
);

  logic [2*REQ_NB-1:0] dbl_d;
  logic [REQ_NB-1:0]   rot_d;
  int                  start_d;

  // Rotate-then-priority-encode; the reverse loop makes the lowest bit win.
  always_comb begin
    start_d  = (int'(last_id_i) + 1) % REQ_NB;
    dbl_d    = {req_i, req_i} >> start_d;
    rot_d    = dbl_d[REQ_NB-1:0];
    found_o  = |rot_d;
    winner_o = '0;
    for (int i = REQ_NB - 1; i >= 0; i--) begin
      if (rot_d[i]) begin
        winner_o = ID_W'((start_d + i) % REQ_NB);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_crossbar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_crossbar_rr_arbiter
// Description : Round-robin arbiter + mux sharing one valid/ready channel.
//               The grant is held from the first beat until the last-beat
//               handshake so bursts never interleave. Data path is purely
//               combinational; the following pipeline stage registers it.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_crossbar_rr_arbiter
  import axi_crossbar_pkg::*;
#(
  parameter int REQ_NB     = 4,
  parameter int DATA_BUS_W = 16
) (
  input  logic                         aclk,
  input  logic                         srst,
  input  logic [REQ_NB-1:0]            i_valid,
  input  logic [REQ_NB-1:0]            i_last,
  input  logic [REQ_NB*DATA_BUS_W-1:0] i_data,
  output logic [REQ_NB-1:0]            i_ready,
  output logic                         o_valid,
  output logic                         o_last,
  output logic [DATA_BUS_W-1:0]        o_data,
  input  logic                         o_ready,
  output logic [calc_id_w(REQ_NB)-1:0] o_grant_id,
  output logic                         o_busy
);

  localparam int ID_W = calc_id_w(REQ_NB);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [ID_W-1:0] pick_id;
  logic            pick_found;

  axi_crossbar_rr_picker #(
    .REQ_NB (REQ_NB),
    .ID_W   (ID_W)
  ) u_picker (
    .req_i     (i_valid),
    .last_id_i (last_id_q),
    .winner_o  (pick_id),
    .found_o   (pick_found)
  );

  // State and pointer registers; last_id resets to the top slot so that
  // requester 0 is searched first.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(REQ_NB - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

  // Next-state logic and output mux; IDLE drives an all-zero channel.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    o_valid    = 1'b0;
    o_last     = 1'b0;
    o_data     = '0;
    i_ready    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          state_d    = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        for (int k = 0; k < REQ_NB; k++) begin
          if (grant_id_q == ID_W'(k)) begin
            o_valid    = i_valid[k];
            o_last     = i_last[k];
            o_data     = i_data[k*DATA_BUS_W +: DATA_BUS_W];
            i_ready[k] = o_ready;
          end
        end
        // i_last only matters on a handshake cycle.
        if (o_valid && o_ready && o_last) begin
          last_id_d = grant_id_q;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign o_grant_id = grant_id_q;
  assign o_busy     = (state_q == ARB_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_axi_crossbar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_crossbar_rr_arbiter
// Description : Directed bench: a cycle-by-cycle vector table for reset,
//               a single burst and fairness, then hand-written sequences for
//               backpressure, valid drop, idle-requester skip and mid-packet
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_crossbar_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           srst;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   i_last;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_ready;
  logic           o_valid;
  logic           o_last;
  logic [W-1:0]   o_data;
  logic           o_ready;
  logic [1:0]     o_grant_id;
  logic           o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  axi_crossbar_rr_arbiter #(
    .REQ_NB     (N),
    .DATA_BUS_W (W)
  ) dut (
    .aclk       (clk),
    .srst       (srst),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_data     (o_data),
    .o_ready    (o_ready),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   v;
    logic [3:0]   l;
    logic [7:0]   b;
    logic         rdy;
    logic         ev;
    logic         el;
    logic [15:0]  ed;
    logic [3:0]   erdy;
    logic [1:0]   eg;
    logic         eb;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [7:0] b, input logic rdy, input logic ev,
                              input logic el, input logic [15:0] ed, input logic [3:0] erdy,
                              input logic [1:0] eg, input logic eb);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.b = b; t.rdy = rdy;
    t.ev = ev; t.el = el; t.ed = ed; t.erdy = erdy; t.eg = eg; t.eb = eb;
    return t;
  endfunction

  // Requester k presents {k, 0, beat} so the source of o_data is visible.
  task automatic set_data(input logic [7:0] b);
    for (int k = 0; k < N; k++) begin
      i_data[k*W +: W] = {4'(k), 4'h0, b};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [24:0] act_v, exp_v;

  initial begin
    // Table: one row per cycle; outputs checked before the rising edge.
    //              rst  v      l      b      rdy  ev   el   ed        erdy   eg  eb
    vecs[0]  = mk(1'b1, 4'hF, 4'h0, 8'h00, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[1]  = mk(1'b1, 4'hF, 4'hF, 8'h55, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[2]  = mk(1'b0, 4'h4, 4'h0, 8'hA1, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[3]  = mk(1'b0, 4'h4, 4'h0, 8'hA1, 1'b1, 1'b1,1'b0,16'h20A1,4'h4,2'd2,1'b1);
    vecs[4]  = mk(1'b0, 4'h4, 4'h0, 8'hA2, 1'b1, 1'b1,1'b0,16'h20A2,4'h4,2'd2,1'b1);
    vecs[5]  = mk(1'b0, 4'h4, 4'h4, 8'hA3, 1'b1, 1'b1,1'b1,16'h20A3,4'h4,2'd2,1'b1);
    vecs[6]  = mk(1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd2,1'b0);
    vecs[7]  = mk(1'b1, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd2,1'b0);
    vecs[8]  = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[9]  = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h0011,4'h1,2'd0,1'b1);
    vecs[10] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[11] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h1011,4'h2,2'd1,1'b1);
    vecs[12] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd1,1'b0);
    vecs[13] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h2011,4'h4,2'd2,1'b1);
    vecs[14] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd2,1'b0);
    vecs[15] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h3011,4'h8,2'd3,1'b1);
    vecs[16] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd3,1'b0);
    vecs[17] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h0011,4'h1,2'd0,1'b1);
    vecs[18] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b0,1'b0,16'h0000,4'h0,2'd0,1'b0);
    vecs[19] = mk(1'b0, 4'hF, 4'hF, 8'h11, 1'b1, 1'b1,1'b1,16'h1011,4'h2,2'd1,1'b1);

    srst = 1'b1; i_valid = '0; i_last = '0; o_ready = 1'b0;
    set_data(8'h00);
    tick(); tick();

    for (int i = 0; i < 20; i++) begin
      srst = vecs[i].rst; i_valid = vecs[i].v; i_last = vecs[i].l;
      o_ready = vecs[i].rdy; set_data(vecs[i].b);
      #1;
      act_v = {o_valid, o_last, o_data, i_ready, o_grant_id, o_busy};
      exp_v = {vecs[i].ev, vecs[i].el, vecs[i].ed, vecs[i].erdy, vecs[i].eg, vecs[i].eb};
      chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
      tick();
    end
    // Now IDLE, last_id = 1.

    // Backpressure: requester 0, two beats, o_ready low on the last beat.
    i_valid = 4'h1; i_last = 4'h0; o_ready = 1'b1; set_data(8'hB1);
    tick();
    chk("bp_grant", 32'(o_grant_id), 32'd0);
    chk("bp_beat1", 32'(o_data), 32'h00B1);
    tick();
    i_valid = 4'h9; i_last = 4'h9; o_ready = 1'b0; set_data(8'hB2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_hold%0d", c),
          32'({o_valid, o_last, o_data, i_ready, o_grant_id, o_busy}),
          32'({1'b1, 1'b1, 16'h00B2, 4'h0, 2'd0, 1'b1}));
      tick();
    end
    o_ready = 1'b1;
    #1;
    chk("bp_release", 32'(i_ready), 32'h1);
    tick();
    chk("bp_idle", 32'({o_busy, o_valid}), 32'd0);
    tick();
    chk("bp_next_grant3", 32'({o_grant_id, o_busy}), 32'({2'd3, 1'b1}));

    // Valid drop mid-packet keeps the lock; o_valid follows.
    i_valid = 4'h0; i_last = 4'h0;
    #1;
    chk("drop_valid", 32'({o_valid, o_busy, o_grant_id}), 32'({1'b0, 1'b1, 2'd3}));
    tick();
    chk("drop_still_locked", 32'({o_busy, o_grant_id}), 32'({1'b1, 2'd3}));
    i_valid = 4'h8; i_last = 4'h8;
    tick();
    // IDLE, last_id = 3.

    // Skip of idle requesters.
    i_valid = 4'h2; i_last = 4'h2;
    tick();
    chk("skip_g1", 32'(o_grant_id), 32'd1);
    tick();
    i_valid = 4'hA; i_last = 4'hA;
    tick();
    chk("skip_g3", 32'({o_grant_id, o_busy}), 32'({2'd3, 1'b1}));
    tick();
    tick();
    chk("skip_g1b", 32'({o_grant_id, o_busy}), 32'({2'd1, 1'b1}));
    tick();
    i_valid = 4'h0; i_last = 4'h0;
    tick();
    // IDLE, last_id = 1.

    // Reset on beat 2 of a packet from requester 3.
    i_valid = 4'h8; i_last = 4'h0; set_data(8'hC1);
    tick();
    chk("rst_g3", 32'({o_grant_id, o_busy}), 32'({2'd3, 1'b1}));
    tick();
    set_data(8'hC2); srst = 1'b1;
    tick();
    srst = 1'b0; i_valid = 4'h9;
    #1;
    chk("rst_idle", 32'({o_valid, o_busy, o_data}), 32'({1'b0, 1'b0, 16'h0000}));
    tick();
    chk("rst_next_g0", 32'({o_grant_id, o_busy, o_data}), 32'({2'd0, 1'b1, 16'h00C2}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_crossbar_rr_arbiter.md
# axi_crossbar_rr_arbiter

Round-robin arbiter and multiplexer that shares one valid/ready channel, typically the input of an `axi_crossbar_pipeline` stage, between `REQ_NB` requesters. The grant is locked from the first beat of a packet until the handshake of its `last` beat, so bursts are never interleaved. It sits in front of each master-side and slave-side channel of the crossbar where several sources contend for one destination.

## Interface
- `REQ_NB`, 4: number of requesters; legal values are 1 and up.
- `DATA_BUS_W`, 16: payload width per requester.
- `ID_W`, `$clog2(REQ_NB)` with a minimum of 1: width of the grant index (localparam).

- `aclk`  in  1  clock; all logic is on the rising edge.
- `srst`  in  1  reset, synchronous and active-high; it overrides every other input.
- `i_valid`  in  REQ_NB  per-requester valid.
- `i_last`  in  REQ_NB  per-requester last-beat flag.
- `i_data`  in  REQ_NB*DATA_BUS_W  payloads; requester k occupies bits `[k*DATA_BUS_W +: DATA_BUS_W]`.
- `i_ready`  out  REQ_NB  per-requester ready.
- `o_valid`  out  1  valid of the shared channel.
- `o_last`  out  1  last flag of the shared channel.
- `o_data`  out  DATA_BUS_W  payload of the shared channel.
- `o_ready`  in  1  ready of the shared channel.
- `o_grant_id`  out  ID_W  index of the current or most recent grant.
- `o_busy`  out  1  high while the FSM is in LOCKED.

## Operation
- Two-state FSM: IDLE and LOCKED. The state, `grant_id` and `last_id` are registers.
- **IDLE**
  - `o_valid`=0 and `i_ready`=0.
  - If any `i_valid` bit is set, the FSM picks the first requesting index, searching upward and cyclically from `last_id+1` mod `REQ_NB`.
  - It registers that index into `grant_id` and moves to LOCKED.
- **LOCKED**, with g = `grant_id`
  - `o_valid`=`i_valid[g]`, `o_last`=`i_last[g]`, `o_data`=slice g.
  - `i_ready[g]`=`o_ready`; every other `i_ready` bit is 0.
  - A handshake is `o_valid && o_ready`.
  - On a handshake with `o_last`=1, `last_id`<=g and the FSM returns to IDLE.
  - Other requesters are ignored for the whole packet.
- `o_grant_id` is always `grant_id`. `o_busy` = (state==LOCKED).
- Boundary rules:
  - If `i_valid[g]` drops mid-packet, the grant stays locked and `o_valid` follows it to 0.
  - With `REQ_NB`=1 the FSM still passes through IDLE between packets.
  - `i_last` is sampled only on handshake cycles.
  - A packet without `last` holds the grant indefinitely; no timeout.

## Timing
- Reset values after `srst`:
  - FSM in IDLE, `grant_id`=0, `last_id`=`REQ_NB`-1, so requester 0 has first priority.
  - `o_valid`=0, `o_last`=0, `o_data`=0 (IDLE forces a zero mux), `i_ready`=0, `o_grant_id`=0, `o_busy`=0.
- Arbitration latency:
  - A request seen in IDLE on cycle t produces a grant at the edge ending t.
  - The first beat can therefore be presented and accepted in cycle t+1.
- Inter-packet bubble: the last-beat handshake in cycle t puts the FSM in IDLE at t+1. The next grant is visible at t+2, a 1-cycle gap. This is intentional and not optimised.
- Data path is combinational from the granted requester to the output; there are no data registers in this block. The downstream pipeline stage provides registration.
- `srst` mid-packet:
  - The packet is abandoned and the FSM goes to IDLE on the next cycle.
  - Pointers reset as above.
  - Partially transferred beats are not replayed.
- Simultaneous events:
  - When a last-beat handshake coincides with new requests, the new requests are arbitrated in the following IDLE cycle using the updated `last_id`.
  - `srst` together with a handshake: `srst` wins.

## Structure
- Shared package `axi_crossbar_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t`.
  - A function computing `ID_W` from `REQ_NB` with a minimum of 1.
- One sub-module, `axi_crossbar_rr_picker`:
  - Purely combinational.
  - Inputs: `REQ_NB`-bit request vector and the `last_id` pointer.
  - Outputs: index of the next winner and a `found` flag.
  - Implemented as a double-width vector rotate plus a priority encode.
- The FSM, registers and output mux live in `axi_crossbar_rr_arbiter`.

## Test plan
- **Reset:** hold `srst`=1 with all `i_valid`=1 → `o_valid`=0, `i_ready`=0000, `o_grant_id`=0, `o_busy`=0.
- **Single packet:** requester 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with last on the third beat), `o_ready`=1, request at cycle 0 →
  - `o_grant_id`=2 and `o_busy`=1 from cycle 1;
  - beats accepted in cycles 1–3;
  - IDLE at cycle 4.
- **Fairness:** all 4 requesters continuously send 1-beat packets with `o_ready`=1 → grant order 0,1,2,3,0,1, one packet every 2 cycles.
- **Backpressure:** `o_ready`=0 for 3 cycles mid-packet →
  - `o_data`/`o_last` stay stable and `i_ready[g]`=0;
  - requester 3 asserting valid does not change the grant;
  - the packet completes after `o_ready`=1.
- **Skip of idle requesters:** after a grant to 1 completes, only requesters 1 and 3 request → next grants are 3 then 1.
- **Reset mid-packet:** `srst` pulsed on beat 2 of a 4-beat packet from requester 3 →
  - next cycle `o_valid`=0 and `o_busy`=0;
  - with requesters 0 and 3 requesting, the next grant is 0.
